// File: rtl/conv2d_stream_3x3.sv
// rtl/conv2d_stream_3x3.sv - streaming 3x3 signed fixed-point convolution over one frame
//
// Purpose: raster-scans a padded IMG_W x IMG_H frame, builds 3x3 windows from two
// line buffers plus a window shift register, and emits one convolution result per
// complete (stride-aligned) window through a two-stage multiply / sum pipeline.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle frame start, honoured in IDLE only
//   relu_en             clamp negative results to zero, latched at start
//   cfg_we/addr/data    weight (addr 0..8, row-major) and bias (addr 9) writes, ignored while busy
//   in_data/valid/ready input pixel handshake, raster order
//   out_data/valid/last convolution result stream, last marks the final output
//   busy                frame in progress (RUN and DRAIN)
//   frame_done          one-cycle pulse at the end of the frame
module conv2d_stream_3x3 #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PAD        = 1,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int PW     = IMG_W + 2 * PAD;
  localparam int PH     = IMG_H + 2 * PAD;
  localparam int OUT_W  = (PW - 3) / STRIDE + 1;
  localparam int OUT_H  = (PH - 3) / STRIDE + 1;
  localparam int RW     = $clog2(PH);
  localparam int CW     = $clog2(PW);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + 4;
  // Bottom-right padded coordinate of the final emitted window.
  localparam int LAST_R = 2 + (OUT_H - 1) * STRIDE;
  localparam int LAST_C = 2 + (OUT_W - 1) * STRIDE;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   r;
  logic [CW-1:0]   c;
  logic            drain_cnt;
  logic            relu_q;
  logic            pad_pos, last_pos, advance;
  logic            win_done, stride_ok, last_win;

  logic signed [DATA_WIDTH-1:0] w [0:8];
  logic signed [DATA_WIDTH-1:0] bias;
  logic signed [DATA_WIDTH-1:0] lb0 [0:PW-1];  // row r-1
  logic signed [DATA_WIDTH-1:0] lb1 [0:PW-1];  // row r-2
  logic signed [DATA_WIDTH-1:0] win [0:8];     // row-major, column 2 is newest
  logic signed [DATA_WIDTH-1:0] pix;
  logic                         win_v, win_last;

  logic signed [PROD_W-1:0]     prod [0:8];
  logic                         p_v, p_last;

  logic signed [ACC_W-1:0]      acc, res;
  logic [DATA_WIDTH-1:0]        sat;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    advance    = 1'b0;
    pad_pos    = (PAD != 0) && ((r == '0) || (r == RW'(PH - 1)) ||
                                (c == '0) || (c == CW'(PW - 1)));
    last_pos   = (r == RW'(PH - 1)) && (c == CW'(PW - 1));
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !pad_pos;
        // Border positions inject zero and never wait on the source.
        advance  = pad_pos || in_valid;
        if (advance && last_pos) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nx = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r         <= '0;
      c         <= '0;
      drain_cnt <= 1'b0;
      relu_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        r      <= '0;
        c      <= '0;
        relu_q <= relu_en;
      end else if (advance) begin
        if (c == CW'(PW - 1)) begin
          c <= '0;
          r <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
      drain_cnt <= (state == S_DRAIN) ? !drain_cnt : 1'b0;
    end
  end

  // ---------------- configuration ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) w[i] <= '0;
      bias <= '0;
    end else if (cfg_we && !busy) begin
      if (cfg_addr < 4'd9)       w[cfg_addr] <= cfg_data;
      else if (cfg_addr == 4'd9) bias        <= cfg_data;
    end
  end

  // ---------------- line buffers and window ----------------
  assign pix       = pad_pos ? '0 : in_data;
  assign win_done  = (r >= RW'(2)) && (c >= CW'(2));
  // (r-2) and (c-2) are even exactly when r and c are even.
  assign stride_ok = (STRIDE == 1) || (!r[0] && !c[0]);
  assign last_win  = (r == RW'(LAST_R)) && (c == CW'(LAST_C));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PW; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win[i] <= '0;
      win_v    <= 1'b0;
      win_last <= 1'b0;
    end else begin
      win_v    <= 1'b0;
      win_last <= 1'b0;
      if (advance) begin
        lb1[c] <= lb0[c];
        lb0[c] <= pix;
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1[c];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0[c];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix;
        win_v    <= win_done && stride_ok;
        win_last <= win_done && stride_ok && last_win;
      end
    end
  end

  // ---------------- stage 1: products ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod[i] <= '0;
      p_v    <= 1'b0;
      p_last <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) prod[i] <= PROD_W'(w[i]) * PROD_W'(win[i]);
      p_v    <= win_v;
      p_last <= win_last;
    end
  end

  // ---------------- stage 2: sum, rescale, saturate, ReLU ----------------
  always_comb begin
    acc = ACC_W'(bias) <<< FRAC_BITS;
    for (int i = 0; i < 9; i++) acc = acc + ACC_W'(prod[i]);
    res = acc >>> FRAC_BITS;
    if (res > MAX_V)      sat = MAX_V[DATA_WIDTH-1:0];
    else if (res < MIN_V) sat = MIN_V[DATA_WIDTH-1:0];
    else                  sat = res[DATA_WIDTH-1:0];
    if (relu_q && sat[DATA_WIDTH-1]) sat = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= p_v;
      out_last  <= p_v && p_last;
      if (p_v) out_data <= sat;
    end
  end
endmodule

// File: tb/tb_conv2d_stream_3x3.sv
// tb/tb_conv2d_stream_3x3.sv - directed checks of conv2d_stream_3x3 on 4x4 frames
module tb_conv2d_stream_3x3;
  logic        clk = 1'b0;
  logic        rst;
  logic        relu_en;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        start      [3];
  logic [15:0] in_data    [3];
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [15:0] out_data   [3];
  logic        out_valid  [3];
  logic        out_last   [3];
  logic        busy       [3];
  logic        frame_done [3];

  always #5 clk = ~clk;

  // 0: PAD=1 STRIDE=1, 1: PAD=1 STRIDE=2, 2: PAD=0 STRIDE=1
  conv2d_stream_3x3 #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(4), .IMG_H(4), .PAD(1), .STRIDE(1)) dut_p1s1 (
    .clk(clk), .rst(rst), .start(start[0]), .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .busy(busy[0]),
    .frame_done(frame_done[0]));
  conv2d_stream_3x3 #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(4), .IMG_H(4), .PAD(1), .STRIDE(2)) dut_p1s2 (
    .clk(clk), .rst(rst), .start(start[1]), .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .busy(busy[1]),
    .frame_done(frame_done[1]));
  conv2d_stream_3x3 #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(4), .IMG_H(4), .PAD(0), .STRIDE(1)) dut_p0s1 (
    .clk(clk), .rst(rst), .start(start[2]), .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_last(out_last[2]), .busy(busy[2]),
    .frame_done(frame_done[2]));

  int checks = 0;
  int errors = 0;

  logic [15:0] got_data [3][1024];
  logic        got_last [3][1024];
  int          got_n    [3];

  int          w_m [9];
  int          bias_m;
  int          pix_m [16];
  logic [15:0] exp_d [64];
  int          exp_n;

  typedef struct {
    int          dut;
    int          kern;
    int          pixset;
    bit          relu;
    logic [15:0] bias;
    int          idx;
    logic [15:0] expv;
  } vec_t;
  vec_t vecs [20];

  initial begin
    for (int i = 0; i < 3; i++) got_n[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i]) begin
        if (got_n[i] < 1024) begin
          got_data[i][got_n[i]] = out_data[i];
          got_last[i][got_n[i]] = out_last[i];
        end
        got_n[i] = got_n[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] kw(input int kern, input int i);
    case (kern)
      0:       kw = (i == 4) ? 16'h0100 : 16'h0000;
      1:       kw = 16'h0100;
      2:       kw = 16'h7FFF;
      3:       kw = 16'hFF00;
      default: kw = 16'h8000;
    endcase
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic setup(input int kern, input int pixset, input logic [15:0] b);
    for (int i = 0; i < 9; i++) begin
      w_m[i] = int'(shortint'(kw(kern, i)));
      cfg_write(4'(i), kw(kern, i));
    end
    bias_m = int'(shortint'(b));
    cfg_write(4'd9, b);
    for (int k = 0; k < 16; k++) pix_m[k] = (pixset == 0) ? (k + 1) * 256 : 32'h7F00;
  endtask

  // Direct-form reference: explicit zero border, no line buffers.
  task automatic model(input int d, input bit relu);
    int pad, stride, ow;
    longint acc, res;
    pad    = (d == 2) ? 0 : 1;
    stride = (d == 1) ? 2 : 1;
    ow     = (4 + 2 * pad - 3) / stride + 1;
    exp_n  = ow * ow;
    for (int orr = 0; orr < ow; orr++) begin
      for (int oc = 0; oc < ow; oc++) begin
        acc = longint'(bias_m) * 256;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            int pr, pc;
            pr = orr * stride + i - pad;
            pc = oc * stride + j - pad;
            if (pr >= 0 && pr < 4 && pc >= 0 && pc < 4)
              acc += longint'(w_m[i*3+j]) * longint'(pix_m[pr*4+pc]);
          end
        end
        res = acc >>> 8;
        if (res > 32767) res = 32767;
        else if (res < -32768) res = -32768;
        if (relu && res < 0) res = 0;
        exp_d[orr*ow+oc] = 16'(res);
      end
    end
  endtask

  task automatic run_frame(input int d, input bit relu, input bit rnd, input bit noise,
                           input int abort_at, input bit w4_with_start,
                           output int gap, output bit lastdone, output int base);
    int k, guard;
    bit hs;
    gap      = -1;
    lastdone = 1'b0;
    base     = got_n[d];
    relu_en  = relu;
    start[d] = 1'b1;
    if (w4_with_start) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'd4;
      cfg_data = 16'h0100;
    end
    tick();
    start[d] = 1'b0;
    cfg_we   = 1'b0;
    relu_en  = !relu;
    k = 0;
    guard = 0;
    while (k < 16 && guard < 2000) begin
      if (abort_at >= 0 && k == abort_at) break;
      in_data[d]  = pix_m[k][15:0];
      in_valid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        cfg_we   = 1'($urandom_range(0, 1));
        cfg_addr = 4'($urandom_range(0, 15));
        cfg_data = 16'($urandom);
      end
      hs = in_valid[d] && in_ready[d];
      tick();
      if (hs) k++;
      guard++;
    end
    in_valid[d] = 1'b0;
    cfg_we      = 1'b0;
    if (abort_at >= 0) return;
    if (k < 16) begin
      chk("input_handshake_timeout", 64'(k), 64'd16);
      return;
    end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (frame_done[d]) begin
        gap      = n;
        lastdone = out_valid[d] && out_last[d];
        chk("busy_low_at_done", 64'(busy[d]), 64'd0);
        break;
      end
    end
    if (gap < 0) chk("frame_done_timeout", 64'd0, 64'd1);
    tick();
    tick();
  endtask

  // Compares one collected frame against the reference model.
  task automatic check_frame(input string tag, input int d, input int base);
    int nbad, lbad;
    nbad = 0;
    lbad = 0;
    chk({tag, "_count"}, 64'(got_n[d] - base), 64'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (got_data[d][base+i] !== exp_d[i]) nbad++;
      if (got_last[d][base+i] !== (i == exp_n - 1)) lbad++;
    end
    chk({tag, "_bad_outputs"}, 64'(nbad), 64'd0);
    chk({tag, "_bad_last"}, 64'(lbad), 64'd0);
  endtask

  initial begin
    int gap, base, fd, n0;
    bit lastdone;

    vecs[0]  = '{0, 0, 0, 1'b0, 16'h0000,  0, 16'h0100};
    vecs[1]  = '{0, 0, 0, 1'b0, 16'h0000, 15, 16'h1000};
    vecs[2]  = '{0, 1, 0, 1'b0, 16'h0000,  0, 16'h0E00};
    vecs[3]  = '{0, 1, 0, 1'b0, 16'h0000,  5, 16'h3600};
    vecs[4]  = '{0, 1, 0, 1'b0, 16'h0000, 15, 16'h3600};
    vecs[5]  = '{1, 1, 0, 1'b0, 16'h0000,  0, 16'h0E00};
    vecs[6]  = '{1, 1, 0, 1'b0, 16'h0000,  1, 16'h1E00};
    vecs[7]  = '{1, 1, 0, 1'b0, 16'h0000,  2, 16'h3900};
    vecs[8]  = '{1, 1, 0, 1'b0, 16'h0000,  3, 16'h6300};
    vecs[9]  = '{2, 1, 0, 1'b0, 16'h0000,  0, 16'h3600};
    vecs[10] = '{2, 1, 0, 1'b0, 16'h0000,  1, 16'h3F00};
    vecs[11] = '{2, 1, 0, 1'b0, 16'h0000,  2, 16'h5A00};
    vecs[12] = '{2, 1, 0, 1'b0, 16'h0000,  3, 16'h6300};
    vecs[13] = '{0, 2, 1, 1'b0, 16'h0000,  0, 16'h7FFF};
    vecs[14] = '{0, 2, 1, 1'b0, 16'h0000,  5, 16'h7FFF};
    vecs[15] = '{0, 3, 0, 1'b1, 16'h0000,  0, 16'h0000};
    vecs[16] = '{0, 3, 0, 1'b1, 16'h0000,  5, 16'h0000};
    vecs[17] = '{0, 3, 0, 1'b0, 16'h0100,  0, 16'hF300};
    vecs[18] = '{1, 2, 1, 1'b0, 16'h0000,  3, 16'h7FFF};
    vecs[19] = '{0, 4, 1, 1'b0, 16'h0000,  5, 16'h8000};

    rst      = 1'b1;
    relu_en  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = 4'd0;
    cfg_data = 16'd0;
    for (int i = 0; i < 3; i++) begin
      start[i]    = 1'b0;
      in_data[i]  = 16'd0;
      in_valid[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs_dut%0d", i),
          64'({in_ready[i], out_valid[i], out_last[i], busy[i], frame_done[i], out_data[i]}), 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 20; v++) begin
      setup(vecs[v].kern, vecs[v].pixset, vecs[v].bias);
      model(vecs[v].dut, vecs[v].relu);
      run_frame(vecs[v].dut, vecs[v].relu, 1'b0, 1'b0, -1, 1'b0, gap, lastdone, base);
      check_frame($sformatf("v%0d", v), vecs[v].dut, base);
      chk($sformatf("v%0d_spot_out%0d", v, vecs[v].idx),
          64'(got_data[vecs[v].dut][base+vecs[v].idx]), 64'(vecs[v].expv));
      if (v == 0) begin
        chk("done_cycles_after_last_input", 64'(gap), 64'd10);
        chk("last_output_with_done", 64'(lastdone), 64'd1);
      end
    end

    // Stalling source plus config writes while busy.
    setup(1, 0, 16'h0000);
    model(0, 1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b1, -1, 1'b0, gap, lastdone, base);
    check_frame("stall_noise", 0, base);
    run_frame(0, 1'b0, 1'b0, 1'b0, -1, 1'b0, gap, lastdone, base);
    check_frame("weights_kept", 0, base);

    // Reset while presenting input pixel 7.
    setup(0, 0, 16'h0000);
    run_frame(0, 1'b0, 1'b0, 1'b0, 6, 1'b0, gap, lastdone, base);
    rst = 1'b1;
    #1;
    chk("abort_outputs_zero",
        64'({out_valid[0], out_last[0], busy[0], frame_done[0], in_ready[0], out_data[0]}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    n0 = got_n[0];
    fd = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done[0]) fd++;
    end
    tick();
    chk("abort_no_outputs", 64'(got_n[0] - n0), 64'd0);
    chk("abort_no_done", 64'(fd), 64'd0);

    // Reload with w4 cleared, then set it in the same cycle as start.
    setup(0, 0, 16'h0000);
    cfg_write(4'd4, 16'h0000);
    model(0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 1'b0, -1, 1'b1, gap, lastdone, base);
    check_frame("after_abort", 0, base);
    chk("after_abort_out15", 64'(got_data[0][base+15]), 64'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
